// File: rtl/rs_dec_syndrome_calc_if.sv
// Symbol-in / syndrome-out bundle between the deinterleaver, the syndrome
// calculator and the Euclid stage.
interface rs_dec_syndrome_calc_if #(
  parameter int unsigned SYM_W = 8
);
  logic [SYM_W-1:0] i_sym;
  logic             i_sym_valid;
  logic             i_cw_start;
  logic [SYM_W-1:0] o_s0;
  logic [SYM_W-1:0] o_s1;
  logic [SYM_W-1:0] o_s2;
  logic [SYM_W-1:0] o_s3;
  logic             o_synd_sync;
  logic             o_nonzero;
  logic             o_frame_err;

  modport master (
    output i_sym, i_sym_valid, i_cw_start,
    input  o_s0, o_s1, o_s2, o_s3, o_synd_sync, o_nonzero, o_frame_err
  );

  modport slave (
    input  i_sym, i_sym_valid, i_cw_start,
    output o_s0, o_s1, o_s2, o_s3, o_synd_sync, o_nonzero, o_frame_err
  );
endinterface

// File: rtl/rs_dec_syndrome_calc.sv
// RS(32,28) C1 syndrome calculator: Horner evaluation of the received
// polynomial at alpha^0..alpha^3 over GF(2^8) mod 0x11D.
module rs_dec_syndrome_calc #(
  parameter int unsigned N_SYM = 32,
  parameter int unsigned SYM_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  rs_dec_syndrome_calc_if.slave  bus
);

  localparam int unsigned   CW   = $clog2(N_SYM);
  localparam logic [CW-1:0] LAST = CW'(N_SYM - 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [3:0][SYM_W-1:0]   acc, acc_nx;
  logic [3:0][SYM_W-1:0]   synd, synd_nx;
  logic                    done, done_nx;
  logic                    sync, sync_nx;
  logic                    nonzero, nonzero_nx;
  logic                    ferr, ferr_nx;

  function automatic logic [SYM_W-1:0] xtime(input logic [SYM_W-1:0] x);
    return {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? SYM_W'(8'h1D) : '0);
  endfunction

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    acc_nx     = acc;
    done_nx    = 1'b0;
    ferr_nx    = 1'b0;
    // The final accumulators are latched one edge after the last symbol,
    // so a new codeword may load acc in that same cycle.
    sync_nx    = done;
    synd_nx    = done ? acc : synd;
    nonzero_nx = done ? (|acc) : nonzero;

    case (state)
      IDLE: begin
        if (bus.i_sym_valid && bus.i_cw_start) begin
          acc_nx   = {4{bus.i_sym}};
          cnt_nx   = CW'(1);
          state_nx = ACC;
        end
      end
      ACC: begin
        if (bus.i_sym_valid) begin
          if (bus.i_cw_start) begin
            acc_nx  = {4{bus.i_sym}};
            cnt_nx  = CW'(1);
            ferr_nx = 1'b1;
          end else begin
            acc_nx[0] = acc[0] ^ bus.i_sym;
            acc_nx[1] = xtime(acc[1]) ^ bus.i_sym;
            acc_nx[2] = xtime(xtime(acc[2])) ^ bus.i_sym;
            acc_nx[3] = xtime(xtime(xtime(acc[3]))) ^ bus.i_sym;
            if (cnt == LAST) begin
              cnt_nx   = '0;
              done_nx  = 1'b1;
              state_nx = IDLE;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      synd    <= '0;
      done    <= 1'b0;
      sync    <= 1'b0;
      nonzero <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      acc     <= acc_nx;
      synd    <= synd_nx;
      done    <= done_nx;
      sync    <= sync_nx;
      nonzero <= nonzero_nx;
      ferr    <= ferr_nx;
    end
  end

  assign bus.o_s0        = synd[0];
  assign bus.o_s1        = synd[1];
  assign bus.o_s2        = synd[2];
  assign bus.o_s3        = synd[3];
  assign bus.o_synd_sync = sync;
  assign bus.o_nonzero   = nonzero;
  assign bus.o_frame_err = ferr;

endmodule

// File: tb/tb_rs_dec_syndrome_calc.sv
// Directed bench for rs_dec_syndrome_calc: single-error codewords with
// hand-computed syndromes plus gap, restart, back-to-back and reset sequences.
module tb_rs_dec_syndrome_calc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_dec_syndrome_calc_if #(.SYM_W(8)) bus ();

  rs_dec_syndrome_calc #(.N_SYM(32), .SYM_W(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    int         deg;
    logic [7:0] val;
    logic [7:0] e0, e1, e2, e3;
    logic       enz;
  } vec_t;

  vec_t vecs[5];

  int          cyc = 0;
  int          sync_cyc[$];
  logic [31:0] synd_log[$];
  logic        nz_log[$];
  int          ferr_cyc[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          last_drive;
  int          start_drive;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_synd_sync) begin
      sync_cyc.push_back(cyc);
      synd_log.push_back({bus.o_s3, bus.o_s2, bus.o_s1, bus.o_s0});
      nz_log.push_back(bus.o_nonzero);
    end
    if (bus.o_frame_err) ferr_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    sync_cyc.delete();
    synd_log.delete();
    nz_log.delete();
    ferr_cyc.delete();
  endtask

  task automatic send(input logic [7:0] s, input logic st);
    @(negedge clk);
    bus.i_sym       = s;
    bus.i_sym_valid = 1'b1;
    bus.i_cw_start  = st;
    last_drive      = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_sym_valid = 1'b0;
      bus.i_cw_start  = 1'b0;
      bus.i_sym       = 8'h00;
    end
  endtask

  function automatic logic [7:0] cw_sym(input int deg, input logic [7:0] val, input int i);
    return (31 - i == deg) ? val : 8'h00;
  endfunction

  task automatic send_cw(input int deg, input logic [7:0] val, input int maxgap);
    for (int i = 0; i < 32; i++) begin
      send(cw_sym(deg, val, i), i == 0);
      if (i == 0) start_drive = last_drive;
      if (maxgap > 0 && i < 31) idle(int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic check_one_strobe(input string name, input logic [31:0] exp_s, input logic exp_nz);
    check({name, "_strobes"}, sync_cyc.size(), 1);
    check({name, "_ferr_none"}, ferr_cyc.size(), 0);
    if (sync_cyc.size() > 0) begin
      check({name, "_latency"}, sync_cyc[0] - last_drive, 2);
      check({name, "_synd"}, synd_log[0], exp_s);
      check({name, "_nonzero"}, {31'd0, nz_log[0]}, {31'd0, exp_nz});
    end
    check({name, "_held"}, {bus.o_s3, bus.o_s2, bus.o_s1, bus.o_s0}, exp_s);
    check({name, "_sync_low"}, {31'd0, bus.o_synd_sync}, 0);
  endtask

  initial begin
    vecs[0] = '{"zero_cw",  0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{"deg0_01",  0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1};
    vecs[2] = '{"deg1_01",  1, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 1'b1};
    vecs[3] = '{"deg1_80",  1, 8'h80, 8'h80, 8'h1D, 8'h3A, 8'h74, 1'b1};
    vecs[4] = '{"deg3_01",  3, 8'h01, 8'h01, 8'h08, 8'h40, 8'h3A, 1'b1};

    bus.i_sym       = 8'h00;
    bus.i_sym_valid = 1'b0;
    bus.i_cw_start  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_synd", {bus.o_s3, bus.o_s2, bus.o_s1, bus.o_s0}, 32'h0);
    check("rst_flags", {29'd0, bus.o_synd_sync, bus.o_nonzero, bus.o_frame_err}, 32'h0);
    rst = 1'b0;
    idle(2);

    // Table-driven single-error codewords, no gaps
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      send_cw(vecs[v].deg, vecs[v].val, 0);
      idle(4);
      #1;
      check_one_strobe(vecs[v].name,
                       {vecs[v].e3, vecs[v].e2, vecs[v].e1, vecs[v].e0}, vecs[v].enz);
    end

    // Gaps between symbols
    clear_logs();
    send_cw(2, 8'h01, 3);
    idle(4);
    #1;
    check_one_strobe("gaps_deg2", {8'h40, 8'h10, 8'h04, 8'h01}, 1'b1);

    // Restart after 10 symbols
    clear_logs();
    for (int i = 0; i < 10; i++) send(8'h5A + 8'(i), i == 0);
    send_cw(0, 8'h01, 0);
    idle(4);
    #1;
    check("restart_ferr_count", ferr_cyc.size(), 1);
    if (ferr_cyc.size() > 0) check("restart_ferr_time", ferr_cyc[0] - start_drive, 1);
    check("restart_strobes", sync_cyc.size(), 1);
    if (sync_cyc.size() > 0) check("restart_synd", synd_log[0], 32'h01010101);

    // Back-to-back: zero codeword then degree-1 0x01
    clear_logs();
    send_cw(0, 8'h00, 0);
    for (int i = 0; i < 32; i++) begin
      send(cw_sym(1, 8'h01, i), i == 0);
      if (i == 16) begin
        #1;
        check("b2b_held_mid", {bus.o_s3, bus.o_s2, bus.o_s1, bus.o_s0}, 32'h0);
        check("b2b_nz_mid", {31'd0, bus.o_nonzero}, 0);
      end
    end
    idle(4);
    #1;
    check("b2b_strobes", sync_cyc.size(), 2);
    check("b2b_ferr_none", ferr_cyc.size(), 0);
    if (sync_cyc.size() == 2) begin
      check("b2b_spacing", sync_cyc[1] - sync_cyc[0], 32);
      check("b2b_first", synd_log[0], 32'h0);
      check("b2b_second", synd_log[1], 32'h08040201);
      check("b2b_second_nz", {31'd0, nz_log[1]}, 1);
    end
    check("b2b_held_end", {bus.o_s3, bus.o_s2, bus.o_s1, bus.o_s0}, 32'h08040201);

    // Reset mid-codeword, stray symbols, then a clean codeword
    clear_logs();
    for (int i = 0; i < 15; i++) send(8'hA5, i == 0);
    @(negedge clk);
    rst             = 1'b1;
    bus.i_sym_valid = 1'b0;
    bus.i_cw_start  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_synd", {bus.o_s3, bus.o_s2, bus.o_s1, bus.o_s0}, 32'h0);
    check("midrst_flags", {29'd0, bus.o_synd_sync, bus.o_nonzero, bus.o_frame_err}, 32'h0);
    for (int i = 0; i < 5; i++) send(8'h55, 1'b0);
    idle(3);
    #1;
    check("midrst_no_strobe", sync_cyc.size(), 0);
    check("stray_no_update", {bus.o_s3, bus.o_s2, bus.o_s1, bus.o_s0}, 32'h0);
    send_cw(3, 8'h01, 0);
    idle(4);
    #1;
    check_one_strobe("post_rst_deg3", {8'h3A, 8'h40, 8'h08, 8'h01}, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_dec_syndrome_calc.md
Name: rs_dec_syndrome_calc

Overview:
Computes the four Reed-Solomon syndromes S0..S3 of a C1 codeword (RS(32,28) over GF(2^8), generator roots alpha^0..alpha^3, field polynomial x^8+x^4+x^3+x^2+1, i.e. 0x11D, alpha = 0x02).
Sits directly upstream of rs_dec_euclid_alg.
- Consumes the deinterleaved symbol stream one symbol per valid cycle.
- Presents S0..S3 with a one-cycle o_synd_sync strobe; this strobe drives the Euclid stage's i_synd_sync, and o_s0..o_s3 drive its i_s0..i_s3.

Parameters:
N_SYM, 32, codeword length in symbols; counter width is clog2(N_SYM).
SYM_W, 8, symbol width; fixed at 8, and any other value is unsupported.

Ports:
i_clk  input  1  system clock, all logic on rising edge.
i_rst  input  1  reset; synchronous, active-high. One clock; reset is synchronous and active-high.
i_sym  input  8  received symbol, highest-degree coefficient first.
i_sym_valid  input  1  i_sym is valid this cycle.
i_cw_start  input  1  qualifies the first symbol of a codeword; only sampled when i_sym_valid=1.
o_s0  output  8  syndrome S0, held until the next completion.
o_s1  output  8  syndrome S1.
o_s2  output  8  syndrome S2.
o_s3  output  8  syndrome S3.
o_synd_sync  output  1  one-cycle strobe: o_s0..o_s3 are newly updated.
o_nonzero  output  1  OR of all four syndromes; updated together with o_s*.
o_frame_err  output  1  one-cycle strobe: a codeword restart was seen before N_SYM symbols were received.

Behaviour:
- Reset (i_rst=1 at a clock edge): accumulators A0..A3=0, symbol counter=0, state IDLE, o_s0..o_s3=0, o_synd_sync=0, o_nonzero=0, o_frame_err=0. Reset dominates every other input, including in mid-codeword.
- Horner accumulation per accepted symbol: Aj <= Aj*alpha^j XOR i_sym.
  - Multiplication by alpha^j uses a constant GF(2^8) multiplier, reduced mod 0x11D. A0 is a pure XOR.
- States:
  - IDLE: symbols with i_cw_start=0 are ignored.
  - IDLE -> ACC: on i_sym_valid & i_cw_start. Aj <= i_sym for every j (the accumulator is treated as 0), counter <= 1.
  - ACC: each i_sym_valid & !i_cw_start applies the Horner step and does counter+1. Cycles with i_sym_valid=0 are gaps: nothing changes, and gaps of any length are allowed.
  - ACC, completion: when the accepted symbol makes counter reach N_SYM:
    - next cycle o_s j = final Aj, o_nonzero = |(final Aj), o_synd_sync = 1 for exactly one cycle;
    - counter <= 0; state -> IDLE.
  - ACC, restart: i_cw_start with i_sym_valid while in ACC (counter < N_SYM):
    - the partial codeword is discarded and o_frame_err = 1 the next cycle;
    - the new symbol is loaded as in IDLE -> ACC and the state stays ACC;
    - o_s*, o_nonzero and o_synd_sync are not updated.
- Latency: o_synd_sync rises on the clock edge after the edge that accepted symbol N_SYM.
- Back-to-back operation:
  - i_cw_start may arrive the cycle immediately after the last symbol, so a codeword may start in the same cycle o_synd_sync is high.
  - Throughput is one codeword per N_SYM valid cycles.
- Output hold: o_s*/o_nonzero are registered and change only at completion. The downstream stage may sample them at any time after the strobe until the next strobe.
- No back-pressure: the downstream stage must finish with the syndromes within N_SYM cycles. This block never stalls.
- Symbol order: the first symbol is the coefficient of x^(N_SYM-1); the last is the coefficient of x^0.

Test Plan:
1. All-zero codeword (start + 32 symbols of 0x00, no gaps) -> o_synd_sync 1 cycle after the 32nd symbol; o_s0..o_s3=0x00; o_nonzero=0.
2. Single error at degree 0: 31 zeros, then last symbol 0x01 -> S0..S3 = 0x01,0x01,0x01,0x01; o_nonzero=1. Error 0x01 at degree 1 -> 0x01,0x02,0x04,0x08. Error 0x80 at degree 1 -> S0=0x80, S1=0x1D.
3. Error 0x01 at degree 2, with random 0-3 cycle gaps between symbols -> 0x01,0x04,0x10,0x40. Result and strobe timing relative to the last valid symbol are identical to the no-gap case.
4. Restart: start, 10 symbols, then i_cw_start with a new full codeword from test 2 (degree 0, 0x01) -> o_frame_err pulses once the cycle after the restart. No o_synd_sync for the aborted codeword. Final syndromes are 0x01 x4.
5. Back-to-back: two codewords with no idle cycle (zero codeword, then degree-1 0x01) -> two strobes exactly 32 cycles apart. Values 0/0/0/0, then 01/02/04/08, held between strobes.
6. Reset mid-codeword at symbol 15 -> all outputs 0 the next cycle, no strobe. A following clean codeword computes correctly; symbols without i_cw_start after reset are ignored.
